res_bram_reader: RTL and testbench

Read-side sequencer for the result accumulator BRAM. On start it streams rows 0..num_rows-1 out of the BRAM's synchronous read port and presents them on a valid/ready output stream. The stream feeds the downstream quantise/writeback stage. The block absorbs the BRAM's 1-cycle read latency and downstream backpressure with a 2-entry output FIFO, and sustains 1 row/cycle when out_ready is held high.

---
 rtl/res_bram_reader.sv | 148 ++++++++++++++
 tb/tb_res_bram_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/res_bram_reader.sv
// Read-side sequencer for the result accumulator BRAM: streams rows 0..num_rows-1
// out of a registered-output BRAM onto a valid/ready stream via a 2-entry FIFO.
module res_bram_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          num_rows,
    output logic                         busy,
    output logic                         done,
    output logic                         bram_rd_en,
    output logic [ADDR_WIDTH-1:0]        bram_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] bram_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]        out_index,
    output logic                         out_last
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH + 1)'(DEPTH);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH:0]   r_total;
    logic [ADDR_WIDTH:0]   r_issued;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflightIdx;

    logic signed [DATA_WIDTH-1:0] r_fifoData [2];
    logic [ADDR_WIDTH-1:0]        r_fifoIdx  [2];
    logic                         r_wrPtr;
    logic                         r_rdPtr;
    logic [1:0]                   r_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_rdEn;
    logic                  w_last;
    logic [2:0]            w_occupancy;
    logic [ADDR_WIDTH:0]   w_clampedRows;
    logic [ADDR_WIDTH:0]   w_headIdxWide;

    assign w_pop         = out_valid & out_ready;
    assign w_push        = r_inflight;
    assign w_headIdxWide = {1'b0, r_fifoIdx[r_rdPtr]};
    assign w_clampedRows = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;

    // Entries already owed to the FIFO (stored + in flight) after this cycle's pop.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_rdEn = 1'b0;
        if (r_state == S_RUN && r_issued < r_total && w_occupancy < 3'd2) begin
            w_rdEn = 1'b1;
        end
    end

    assign w_last = (r_count != 2'd0) && (w_headIdxWide == r_total - 1'b1);

    assign bram_rd_en   = w_rdEn;
    assign bram_rd_addr = r_issued[ADDR_WIDTH-1:0];
    assign out_valid    = (r_count != 2'd0);
    assign out_data     = r_fifoData[r_rdPtr];
    assign out_index    = r_fifoIdx[r_rdPtr];
    assign out_last     = w_last;
    assign busy         = (r_state == S_RUN) || (r_state == S_FIN);
    assign done         = (r_state == S_FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_total  <= '0;
            r_issued <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_total  <= w_clampedRows;
                        r_issued <= '0;
                        r_state  <= (w_clampedRows == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_rdEn) begin
                        r_issued <= r_issued + 1'b1;
                    end
                    if (w_pop && w_last) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after the enable; remember which row it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight    <= 1'b0;
            r_inflightIdx <= '0;
        end else begin
            r_inflight    <= w_rdEn;
            r_inflightIdx <= bram_rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifoData[0] <= '0;
            r_fifoData[1] <= '0;
            r_fifoIdx[0]  <= '0;
            r_fifoIdx[1]  <= '0;
            r_wrPtr       <= 1'b0;
            r_rdPtr       <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push && !w_pop) begin
                assert (r_count != 2'd2);
            end
            if (w_push) begin
                r_fifoData[r_wrPtr] <= bram_rd_data;
                r_fifoIdx[r_wrPtr]  <= r_inflightIdx;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_res_bram_reader.sv
// Directed bench for res_bram_reader with a registered-output BRAM model and
// per-drain bookkeeping of issued reads, handshakes, stalls and done pulses.
module tb_res_bram_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] numRows;
    logic        busy;
    logic        done;
    logic        bram_rd_en;
    logic [9:0]  bram_rd_addr;
    logic [31:0] bramRdData;
    logic        out_valid;
    logic        outReady;
    logic [31:0] out_data;
    logic [9:0]  out_index;
    logic        out_last;

    logic [31:0] mem [1024];
    int          readCount [1024];

    int checkCount = 0;
    int passCount  = 0;

    int beats, orderErr, creditErr, stallErr, lastErr, gapErr;
    int doneCnt, doneCyc, firstValid, lastBeatCyc, issuedCnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_rd_en) bramRdData <= mem[bram_rd_addr];
    end

    res_bram_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_rows     (numRows),
        .busy         (busy),
        .done         (done),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bramRdData),
        .out_valid    (out_valid),
        .out_ready    (outReady),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n);
        start   = 1'b1;
        numRows = 11'(n);
        waitCycle();
        start   = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_rden"}, 64'(bram_rd_en), 64'd0);
        checkOutput({tag, "_addr"}, 64'(bram_rd_addr), 64'd0);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_data"}, 64'(out_data), 64'd0);
        checkOutput({tag, "_index"}, 64'(out_index), 64'd0);
        checkOutput({tag, "_last"}, 64'(out_last), 64'd0);
    endtask

    // Watches one drain cycle by cycle; cycle 1 is the cycle after the start edge.
    task automatic runDrain(input int n, input int mode, input int budget, input int injectCyc);
        int          cyc, stopAt, popped;
        logic        pop, prevStall;
        logic [31:0] savedData;
        logic [9:0]  savedIdx;
        beats = 0; orderErr = 0; creditErr = 0; stallErr = 0; lastErr = 0; gapErr = 0;
        doneCnt = 0; doneCyc = -1; firstValid = -1; lastBeatCyc = -1; issuedCnt = 0;
        popped = 0; prevStall = 1'b0; savedData = '0; savedIdx = '0;
        for (int i = 0; i < 1024; i++) readCount[i] = 0;
        stopAt = budget;
        cyc = 1;
        while (cyc <= stopAt) begin
            outReady = (mode == 0) ? 1'b1 : cyc[0];
            start    = (cyc == injectCyc);
            if (cyc == injectCyc) numRows = 11'd3;
            #1;
            pop = out_valid & outReady;
            if (bram_rd_en) begin
                if (issuedCnt - popped - int'(pop) >= 2) creditErr++;
                if (int'(bram_rd_addr) != issuedCnt) orderErr++;
                readCount[bram_rd_addr]++;
                issuedCnt++;
            end
            if (out_valid && firstValid < 0) firstValid = cyc;
            if (prevStall && (!out_valid || out_data !== savedData || out_index !== savedIdx)) stallErr++;
            if (pop) begin
                if (beats >= 1024 || out_data !== mem[beats] || int'(out_index) != beats) orderErr++;
                if (out_last != (beats == n - 1)) lastErr++;
                if (beats > 0 && cyc != lastBeatCyc + 1) gapErr++;
                lastBeatCyc = cyc;
                beats++;
                popped++;
            end
            prevStall = out_valid & !outReady;
            savedData = out_data;
            savedIdx  = out_index;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc = cyc;
                    stopAt  = cyc + 3;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start    = 1'b0;
        outReady = 1'b1;
    endtask

    task automatic checkDrain(input string tag, input int n, input int mode);
        int readErr;
        readErr = 0;
        for (int i = 0; i < 1024; i++) begin
            if (readCount[i] != ((i < n) ? 1 : 0)) readErr++;
        end
        checkOutput({tag, "_beats"}, 64'(beats), 64'(n));
        checkOutput({tag, "_issued"}, 64'(issuedCnt), 64'(n));
        checkOutput({tag, "_order"}, 64'(orderErr), 64'd0);
        checkOutput({tag, "_credit"}, 64'(creditErr), 64'd0);
        checkOutput({tag, "_stall"}, 64'(stallErr), 64'd0);
        checkOutput({tag, "_last"}, 64'(lastErr), 64'd0);
        checkOutput({tag, "_reads"}, 64'(readErr), 64'd0);
        checkOutput({tag, "_donecnt"}, 64'(doneCnt), 64'd1);
        if (n == 0) begin
            checkOutput({tag, "_donecyc"}, 64'(doneCyc), 64'd1);
            checkOutput({tag, "_novalid"}, 64'(firstValid), 64'(-1));
        end else begin
            checkOutput({tag, "_donecyc"}, 64'(doneCyc), 64'(lastBeatCyc + 1));
            if (mode == 0) begin
                checkOutput({tag, "_firstvalid"}, 64'(firstValid), 64'd3);
                checkOutput({tag, "_gaps"}, 64'(gapErr), 64'd0);
            end
        end
    endtask

    initial begin
        int pops;
        int doneSeen;
        rst = 1'b1; start = 1'b0; numRows = '0; outReady = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
        mem[0] = 32'd10;
        mem[1] = 32'hFFFFFFEC;
        mem[2] = 32'd30;
        mem[3] = 32'h7FFFFFFF;

        repeat (3) waitCycle();
        checkResetOutputs("reset");
        rst = 1'b0;
        waitCycle();

        // Four rows at full rate, checked cycle by cycle.
        applyStimulus(4);
        checkOutput("t1_c1_busy", 64'(busy), 64'd1);
        checkOutput("t1_c1_rden", 64'(bram_rd_en), 64'd1);
        checkOutput("t1_c1_addr", 64'(bram_rd_addr), 64'd0);
        checkOutput("t1_c1_valid", 64'(out_valid), 64'd0);
        waitCycle();
        checkOutput("t1_c2_valid", 64'(out_valid), 64'd0);
        checkOutput("t1_c2_addr", 64'(bram_rd_addr), 64'd1);
        for (int i = 0; i < 4; i++) begin
            waitCycle();
            checkOutput($sformatf("t1_valid%0d", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("t1_data%0d", i), 64'(out_data), 64'(mem[i]));
            checkOutput($sformatf("t1_index%0d", i), 64'(out_index), 64'(i));
            checkOutput($sformatf("t1_last%0d", i), 64'(out_last), 64'(i == 3));
            checkOutput($sformatf("t1_done%0d", i), 64'(done), 64'd0);
        end
        waitCycle();
        checkOutput("t1_done", 64'(done), 64'd1);
        checkOutput("t1_done_busy", 64'(busy), 64'd1);
        checkOutput("t1_done_valid", 64'(out_valid), 64'd0);
        waitCycle();
        checkOutput("t1_after_done", 64'(done), 64'd0);
        checkOutput("t1_after_busy", 64'(busy), 64'd0);

        // Eight rows with alternating backpressure.
        applyStimulus(8);
        runDrain(8, 1, 60, 0);
        checkDrain("t2", 8, 1);

        // Empty drain.
        applyStimulus(0);
        runDrain(0, 0, 10, 0);
        checkDrain("t3", 0, 0);

        // Full depth, then an oversize request that clamps to full depth.
        applyStimulus(1024);
        runDrain(1024, 0, 1100, 0);
        checkDrain("t4", 1024, 0);
        applyStimulus(2000);
        runDrain(1024, 0, 1100, 0);
        checkDrain("t4clamp", 1024, 0);

        // Reset after the fifth beat of a 16-row drain.
        applyStimulus(16);
        outReady = 1'b1;
        pops = 0;
        for (int c = 0; c < 30 && pops < 5; c++) begin
            #1;
            if (out_valid && outReady) pops++;
            if (pops < 5) waitCycle();
        end
        checkOutput("t5_beats_before_rst", 64'(pops), 64'd5);
        rst = 1'b1;
        waitCycle();
        checkResetOutputs("t5_rst");
        rst = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 5; c++) begin
            waitCycle();
            if (done) doneSeen++;
        end
        checkOutput("t5_no_done", 64'(doneSeen), 64'd0);
        applyStimulus(2);
        runDrain(2, 0, 20, 0);
        checkDrain("t5_restart", 2, 0);

        // A second start mid-drain must be ignored.
        applyStimulus(6);
        runDrain(6, 0, 40, 4);
        checkDrain("t6", 6, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
